// File: rtl/axi4_lite_arbiter_2x1_if.sv
// AXI4-Lite channel bundle (no response codes) shared by the arbiter's upstream
// ports and its downstream memory port.
interface axi4_lite_arbiter_2x1_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/axi4_lite_arbiter_2x1.sv
// Two-master to one-slave AXI4-Lite arbiter, one transaction outstanding at a time.
// Round-robin or fixed (master 0 first) arbitration, chosen by FIXED_PRIO.
module axi4_lite_arbiter_2x1 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                            clk,
  input  logic                            resetn,
  axi4_lite_arbiter_2x1_if.slave          s0_axi,
  axi4_lite_arbiter_2x1_if.slave          s1_axi,
  axi4_lite_arbiter_2x1_if.master         mem_axi,
  output logic                            arb_busy,
  output logic                            arb_grant
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t r_state, w_nxt;
  logic   r_grant, r_last, r_aw_done, r_w_done;
  logic   w_req0, w_req1, w_pick, w_pick_wr;

  logic        w_g_awvalid, w_g_wvalid, w_g_arvalid, w_g_bready, w_g_rready;
  logic [31:0] w_g_awaddr, w_g_wdata, w_g_araddr;
  logic [2:0]  w_g_awprot, w_g_arprot;
  logic [3:0]  w_g_wstrb;

  logic        w_awready, w_wready, w_arready, w_bvalid, w_rvalid;
  logic [31:0] w_rdata;

  logic        w_m_awvalid, w_m_wvalid, w_m_arvalid, w_m_bready, w_m_rready;
  logic [31:0] w_m_awaddr, w_m_wdata, w_m_araddr;
  logic [2:0]  w_m_awprot, w_m_arprot;
  logic [3:0]  w_m_wstrb;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_b_hs, w_aw_fin, w_w_fin;

  assign w_req0 = s0_axi.awvalid | s0_axi.arvalid;
  assign w_req1 = s1_axi.awvalid | s1_axi.arvalid;

  // r_last starts at 1 so master 0 takes the first tie after reset
  always_comb begin
    w_pick = 1'b0;
    if (FIXED_PRIO)               w_pick = ~w_req0;
    else if (w_req0 && w_req1)    w_pick = ~r_last;
    else                          w_pick = w_req1;
  end
  assign w_pick_wr = w_pick ? s1_axi.awvalid : s0_axi.awvalid;

  assign w_g_awvalid = r_grant ? s1_axi.awvalid : s0_axi.awvalid;
  assign w_g_awaddr  = r_grant ? s1_axi.awaddr  : s0_axi.awaddr;
  assign w_g_awprot  = r_grant ? s1_axi.awprot  : s0_axi.awprot;
  assign w_g_wvalid  = r_grant ? s1_axi.wvalid  : s0_axi.wvalid;
  assign w_g_wdata   = r_grant ? s1_axi.wdata   : s0_axi.wdata;
  assign w_g_wstrb   = r_grant ? s1_axi.wstrb   : s0_axi.wstrb;
  assign w_g_bready  = r_grant ? s1_axi.bready  : s0_axi.bready;
  assign w_g_arvalid = r_grant ? s1_axi.arvalid : s0_axi.arvalid;
  assign w_g_araddr  = r_grant ? s1_axi.araddr  : s0_axi.araddr;
  assign w_g_arprot  = r_grant ? s1_axi.arprot  : s0_axi.arprot;
  assign w_g_rready  = r_grant ? s1_axi.rready  : s0_axi.rready;

  // Channel forwarding depends only on state, grant and done flags
  always_comb begin
    w_m_awvalid = 1'b0; w_m_awaddr = '0; w_m_awprot = '0;
    w_m_wvalid  = 1'b0; w_m_wdata  = '0; w_m_wstrb  = '0;
    w_m_arvalid = 1'b0; w_m_araddr = '0; w_m_arprot = '0;
    w_m_bready  = 1'b0; w_m_rready = 1'b0;
    w_awready = 1'b0; w_wready = 1'b0; w_arready = 1'b0;
    w_bvalid  = 1'b0; w_rvalid = 1'b0; w_rdata   = '0;
    case (r_state)
      RD_ADDR: begin
        w_m_arvalid = w_g_arvalid;
        w_m_araddr  = w_g_araddr;
        w_m_arprot  = w_g_arprot;
        w_arready   = mem_axi.arready;
      end
      RD_DATA: begin
        w_rvalid   = mem_axi.rvalid;
        w_rdata    = mem_axi.rdata;
        w_m_rready = w_g_rready;
      end
      WR_REQ: begin
        if (!r_aw_done) begin
          w_m_awvalid = w_g_awvalid;
          w_m_awaddr  = w_g_awaddr;
          w_m_awprot  = w_g_awprot;
          w_awready   = mem_axi.awready;
        end
        if (!r_w_done) begin
          w_m_wvalid = w_g_wvalid;
          w_m_wdata  = w_g_wdata;
          w_m_wstrb  = w_g_wstrb;
          w_wready   = mem_axi.wready;
        end
      end
      WR_RESP: begin
        w_bvalid   = mem_axi.bvalid;
        w_m_bready = w_g_bready;
      end
      default: ;
    endcase
  end

  assign w_aw_hs  = w_m_awvalid & mem_axi.awready;
  assign w_w_hs   = w_m_wvalid  & mem_axi.wready;
  assign w_ar_hs  = w_m_arvalid & mem_axi.arready;
  assign w_r_hs   = mem_axi.rvalid & w_m_rready;
  assign w_b_hs   = mem_axi.bvalid & w_m_bready;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done  | w_w_hs;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req0 || w_req1) w_nxt = w_pick_wr ? WR_REQ : RD_ADDR;
      RD_ADDR: if (w_ar_hs)          w_nxt = RD_DATA;
      RD_DATA: if (w_r_hs)           w_nxt = IDLE;
      WR_REQ:  if (w_aw_fin && w_w_fin) w_nxt = WR_RESP;
      WR_RESP: if (w_b_hs)           w_nxt = IDLE;
      default:                       w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && (w_req0 || w_req1)) begin
        r_grant <= w_pick;
        r_last  <= w_pick;
      end
      if (r_state == WR_REQ && w_nxt == WR_REQ) begin
        r_aw_done <= w_aw_fin;
        r_w_done  <= w_w_fin;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
    end
  end

  assign mem_axi.awvalid = w_m_awvalid;
  assign mem_axi.awaddr  = w_m_awaddr;
  assign mem_axi.awprot  = w_m_awprot;
  assign mem_axi.wvalid  = w_m_wvalid;
  assign mem_axi.wdata   = w_m_wdata;
  assign mem_axi.wstrb   = w_m_wstrb;
  assign mem_axi.bready  = w_m_bready;
  assign mem_axi.arvalid = w_m_arvalid;
  assign mem_axi.araddr  = w_m_araddr;
  assign mem_axi.arprot  = w_m_arprot;
  assign mem_axi.rready  = w_m_rready;

  assign s0_axi.awready = w_awready & ~r_grant;
  assign s0_axi.wready  = w_wready  & ~r_grant;
  assign s0_axi.arready = w_arready & ~r_grant;
  assign s0_axi.bvalid  = w_bvalid  & ~r_grant;
  assign s0_axi.rvalid  = w_rvalid  & ~r_grant;
  assign s0_axi.rdata   = r_grant ? '0 : w_rdata;

  assign s1_axi.awready = w_awready & r_grant;
  assign s1_axi.wready  = w_wready  & r_grant;
  assign s1_axi.arready = w_arready & r_grant;
  assign s1_axi.bvalid  = w_bvalid  & r_grant;
  assign s1_axi.rvalid  = w_rvalid  & r_grant;
  assign s1_axi.rdata   = r_grant ? w_rdata : '0;

  assign arb_busy  = (r_state != IDLE);
  assign arb_grant = r_grant;

endmodule
